inv_factorial: RTL and testbench



---
 rtl/inv_factorial.sv | 138 +++++++++++++
 tb/tb_inv_factorial.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inv_factorial.sv
// Iterative inverse-factorial solver: largest n with n! <= value, plus an exact-match flag.
// Optional remainder output (value - n!) is enabled by defining INV_FACT_REMAINDER_EN.
//
//   state | meaning
//   IDLE  | waiting for start; result registers hold the last answer
//   RUN   | one multiply-compare step per clock until n is found
module inv_factorial #(
    parameter int unsigned MAX_N = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] value,
    output logic        busy,
    output logic        done,
    output logic [3:0]  n_out,
`ifdef INV_FACT_REMAINDER_EN
    output logic        exact,
    output logic [31:0] remainder
`else
    output logic        exact
`endif
);

    localparam logic [3:0] MAX_K = 4'(MAX_N);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state_q, state_d;
    logic [31:0] val_q, val_d;
    logic [31:0] prod_q, prod_d;
    logic [3:0]  k_q, k_d;
    logic [3:0]  n_q, n_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        exact_q, exact_d;
    logic [35:0] nxt;
    logic        finish;
`ifdef INV_FACT_REMAINDER_EN
    logic [31:0] rem_q, rem_d;
`endif

    // Full 36-bit product so an overflowing step still compares as "too big".
    assign nxt    = {4'b0, prod_q} * {32'b0, k_q + 4'd1};
    assign finish = (val_q == 32'd0) || (k_q == MAX_K) || (nxt > {4'b0, val_q});

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            val_q   <= 32'd0;
            prod_q  <= 32'd1;
            k_q     <= 4'd1;
            n_q     <= 4'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            exact_q <= 1'b0;
`ifdef INV_FACT_REMAINDER_EN
            rem_q   <= 32'd0;
`endif
        end else begin
            state_q <= state_d;
            val_q   <= val_d;
            prod_q  <= prod_d;
            k_q     <= k_d;
            n_q     <= n_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            exact_q <= exact_d;
`ifdef INV_FACT_REMAINDER_EN
            rem_q   <= rem_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start)  state_d = RUN;
            RUN:     if (finish) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        val_d   = val_q;
        prod_d  = prod_q;
        k_d     = k_q;
        n_d     = n_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        exact_d = exact_q;
`ifdef INV_FACT_REMAINDER_EN
        rem_d   = rem_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    val_d  = value;
                    prod_d = 32'd1;
                    k_d    = 4'd1;
                    busy_d = 1'b1;
                end
            end
            RUN: begin
                if (finish) begin
                    busy_d = 1'b0;
                    done_d = 1'b1;
                    if (val_q == 32'd0) begin
                        n_d     = 4'd0;
                        exact_d = 1'b0;
`ifdef INV_FACT_REMAINDER_EN
                        rem_d   = 32'd0;
`endif
                    end else begin
                        n_d     = k_q;
                        exact_d = (prod_q == val_q);
`ifdef INV_FACT_REMAINDER_EN
                        rem_d   = val_q - prod_q;
`endif
                    end
                end else begin
                    prod_d = nxt[31:0];
                    k_d    = k_q + 4'd1;
                end
            end
            default: ;
        endcase
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign n_out = n_q;
    assign exact = exact_q;
`ifdef INV_FACT_REMAINDER_EN
    assign remainder = rem_q;
`endif

endmodule

// File: tb/tb_inv_factorial.sv
// Self-checking bench for inv_factorial against a factorial-table reference model.
// Remainder checks are active when INV_FACT_REMAINDER_EN is defined.
module tb_inv_factorial;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] value;
    logic        busy;
    logic        done;
    logic [3:0]  n_out;
    logic        exact;
    logic [31:0] remainder;

    int n_cmp  = 0;
    int n_fail = 0;

    inv_factorial #(.MAX_N(12)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .value     (value),
        .busy      (busy),
        .done      (done),
        .n_out     (n_out),
`ifdef INV_FACT_REMAINDER_EN
        .exact     (exact),
        .remainder (remainder)
`else
        .exact     (exact)
`endif
    );

`ifndef INV_FACT_REMAINDER_EN
    assign remainder = 32'd0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: walk the factorial table and keep the largest n with n! <= v.
    function automatic void ref_model(input logic [31:0] v, output int n, output logic ex,
                                      output logic [31:0] rem, output int lat);
        longint unsigned f;
        longint unsigned vv;
        vv  = 64'(v);
        n   = 0;
        ex  = 1'b0;
        rem = 32'd0;
        if (v != 32'd0) begin
            f = 1;
            n = 1;
            for (int i = 2; i <= 12; i++) begin
                if (f * longint'(i) <= vv) begin
                    f = f * longint'(i);
                    n = i;
                end else begin
                    break;
                end
            end
            ex  = (f == vv);
            rem = 32'(vv - f);
        end
        lat = (n > 1) ? n : 1;
    endfunction

    // Issue one start and collect what the DUT reports; the callers do the comparing.
    task automatic do_op(input logic [31:0] v, output int lat, output int busy_cyc,
                         output logic [3:0] n, output logic ex, output logic [31:0] rem);
        @(negedge clk);
        start = 1'b1;
        value = v;
        @(negedge clk);
        start = 1'b0;
        value = $urandom;
        lat = 0;
        busy_cyc = 0;
        while (done !== 1'b1 && lat < 40) begin
            if (busy === 1'b1) busy_cyc++;
            @(negedge clk);
            lat++;
        end
        n   = n_out;
        ex  = exact;
        rem = remainder;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        start = 1'b0;
        value = 32'd0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({busy, done, n_out, exact, remainder} !== 38'd0) begin
                n_fail++;
                $display("FAIL reset_idle cyc %0d: busy=%b done=%b n=%0d exact=%b rem=%0d, want all 0",
                         i, busy, done, n_out, exact, remainder);
            end
        end
    endtask

    task automatic check_op(input string name, input logic [31:0] v);
        int lat, bc, en, el;
        logic [3:0]  n;
        logic        ex, eex;
        logic [31:0] rem, erem;
        ref_model(v, en, eex, erem, el);
        do_op(v, lat, bc, n, ex, rem);
        n_cmp++;
        if (lat != el || bc != el || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s latency v=%0d: lat=%0d busy_cycles=%0d busy@done=%b, want lat=%0d busy_cycles=%0d busy=0",
                     name, v, lat, bc, busy, el, el);
        end
        n_cmp++;
        if (n !== 4'(en) || ex !== eex) begin
            n_fail++;
            $display("FAIL %s result v=%0d: n=%0d exact=%b, want n=%0d exact=%b", name, v, n, ex, en, eex);
        end
`ifdef INV_FACT_REMAINDER_EN
        n_cmp++;
        if (rem !== erem) begin
            n_fail++;
            $display("FAIL %s remainder v=%0d: got %0d, want %0d", name, v, rem, erem);
        end
`endif
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0 || n_out !== 4'(en)) begin
            n_fail++;
            $display("FAIL %s pulse/hold v=%0d: done=%b n=%0d, want done=0 n=%0d", name, v, done, n_out, en);
        end
    endtask

    task automatic test_directed;
        check_op("dir120", 32'd120);
        check_op("dir121", 32'd121);
        check_op("dir0", 32'd0);
        check_op("dir1", 32'd1);
        check_op("dir2", 32'd2);
        check_op("dir12fact", 32'd479001600);
        check_op("dirmax", 32'hFFFF_FFFF);
        check_op("dir11fact_m1", 32'd39916799);
    endtask

    task automatic test_random;
        logic [31:0] f;
        logic [31:0] v;
        for (int i = 0; i < 25; i++) begin
            case ($urandom_range(0, 2))
                0: v = $urandom;
                1: v = $urandom_range(0, 50000);
                default: begin
                    f = 32'd1;
                    for (int j = 2; j <= int'($urandom_range(1, 12)); j++) f = f * 32'(j);
                    v = f + 32'($urandom_range(0, 2)) - 32'd1;
                end
            endcase
            check_op("rand", v);
        end
    endtask

    task automatic test_busy_ignore;
        int lat;
        @(negedge clk);
        start = 1'b1;
        value = 32'd720;
        @(negedge clk);
        start = 1'b0;
        value = 32'd5;
        @(negedge clk);
        start = 1'b1;
        value = 32'd24;
        @(negedge clk);
        start = 1'b0;
        lat = 2;
        while (done !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        n_cmp++;
        if (lat != 6 || n_out !== 4'd6 || exact !== 1'b1) begin
            n_fail++;
            $display("FAIL ignore_busy: lat=%0d n=%0d exact=%b, want lat=6 n=6 exact=1", lat, n_out, exact);
        end
        // start presented in the done cycle must be accepted
        start = 1'b1;
        value = 32'd24;
        @(negedge clk);
        start = 1'b0;
        n_cmp++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL accept_in_done: busy=%b done=%b, want busy=1 done=0", busy, done);
        end
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        n_cmp++;
        if (lat != 4 || n_out !== 4'd4 || exact !== 1'b1) begin
            n_fail++;
            $display("FAIL accept_in_done result: lat=%0d n=%0d exact=%b, want lat=4 n=4 exact=1",
                     lat, n_out, exact);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run;
        int lat, bc;
        logic [3:0]  n;
        logic        ex;
        logic [31:0] rem;
        bit seen_done;
        @(negedge clk);
        start = 1'b1;
        value = 32'd479001600;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({busy, done, n_out, exact, remainder} !== 38'd0) begin
            n_fail++;
            $display("FAIL reset_mid_run: busy=%b done=%b n=%0d exact=%b rem=%0d, want all 0",
                     busy, done, n_out, exact, remainder);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        seen_done = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen_done = 1'b1;
        end
        n_cmp++;
        if (seen_done || n_out !== 4'd0) begin
            n_fail++;
            $display("FAIL post_reset_idle: activity=%b n=%0d, want activity=0 n=0", seen_done, n_out);
        end
        do_op(32'd6, lat, bc, n, ex, rem);
        n_cmp++;
        if (lat != 3 || n !== 4'd3 || ex !== 1'b1) begin
            n_fail++;
            $display("FAIL after_reset v=6: lat=%0d n=%0d exact=%b, want lat=3 n=3 exact=1", lat, n, ex);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        logic [31:0] vals [6];
        int en, el, cnt;
        logic eex;
        logic [31:0] erem;
        vals = '{32'd6, 32'd1, 32'd0, 32'd120, 32'd5040, 32'd25};
        @(negedge clk);
        start = 1'b1;
        value = vals[0];
        cnt = 0;
        while (done !== 1'b1 && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        for (int i = 0; i < 6; i++) begin
            ref_model(vals[i], en, eex, erem, el);
            n_cmp++;
            if (n_out !== 4'(en) || exact !== eex || done !== 1'b1 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b[%0d] v=%0d: done=%b busy=%b n=%0d exact=%b, want done=1 busy=0 n=%0d exact=%b",
                         i, vals[i], done, busy, n_out, exact, en, eex);
            end
            if (i == 5) begin
                start = 1'b0;
            end else begin
                value = vals[i+1];
                ref_model(vals[i+1], en, eex, erem, el);
                cnt = 0;
                do begin
                    @(negedge clk);
                    cnt++;
                end while (done !== 1'b1 && cnt < 40);
                n_cmp++;
                if (cnt != el + 1) begin
                    n_fail++;
                    $display("FAIL b2b_spacing[%0d]: got %0d cycles, want %0d", i + 1, cnt, el + 1);
                end
            end
        end
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        value = 32'd0;
        test_reset();
        test_directed();
        test_random();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
